// File: rtl/vga_rd_scheduler.sv
// VGA timing generator that schedules read-FIFO strobes ahead of the active pixel window
// and blanks frames whenever the FIFO cannot sustain a full frame.
module vga_rd_scheduler #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_DISP   = 640,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_DISP   = 480,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned PREFETCH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        rfifo_rd_ready,
    input  logic        clr_err,
    output logic [11:0] hcnt,
    output logic [11:0] vcnt,
    output logic        hsync,
    output logic        vsync,
    output logic        rfifo_rd_en,
    output logic        disp_en,
    output logic        frame_start,
    output logic        underflow,
    output logic        busy
);

    localparam logic [11:0] HTotM1    = 12'(H_TOTAL - 1);
    localparam logic [11:0] VTotM1    = 12'(V_TOTAL - 1);
    localparam logic [11:0] HSyncEnd  = 12'(H_SYNC);
    localparam logic [11:0] VSyncEnd  = 12'(V_SYNC);
    localparam logic [11:0] RdStart   = 12'(H_SYNC + H_BACK - PREFETCH);
    localparam logic [11:0] RdEnd     = 12'(H_SYNC + H_BACK + H_DISP - PREFETCH);
    localparam logic [11:0] DispStart = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] DispEnd   = 12'(H_SYNC + H_BACK + H_DISP);
    localparam logic [11:0] VActStart = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] VActEnd   = 12'(V_SYNC + V_BACK + V_DISP);
    localparam logic [11:0] FillLine  = 12'(V_SYNC + V_BACK - 1);

    typedef enum logic [1:0] {StIdle, StFill, StRun, StDrain} state_e;

    state_e      state_q, state_d;
    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] vcnt_q, vcnt_d;
    logic        underflow_q, underflow_d;

    logic line_end, frame_end, fill_check, v_active, rd_win, disp_win, rd_en, underrun;

    assign line_end   = (hcnt_q == HTotM1);
    assign frame_end  = line_end && (vcnt_q == VTotM1);
    // Last pixel of the final blank line before the active region: commit point for a frame.
    assign fill_check = line_end && (vcnt_q == FillLine);
    assign v_active   = (vcnt_q >= VActStart) && (vcnt_q < VActEnd);
    assign rd_win     = (hcnt_q >= RdStart) && (hcnt_q < RdEnd) && v_active;
    assign disp_win   = (hcnt_q >= DispStart) && (hcnt_q < DispEnd) && v_active;
    assign rd_en      = (state_q == StRun) && rd_win;
    assign underrun   = rd_en && !rfifo_rd_ready;

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        underflow_d = underflow_q;

        if (underrun) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end

        if (state_q == StIdle) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (line_end) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VTotM1) ? 12'd0 : vcnt_q + 12'd1;
        end else begin
            hcnt_d = hcnt_q + 12'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StFill;
            end
            StFill: begin
                if (!enable) begin
                    state_d = StDrain;
                end else if (fill_check && rfifo_rd_ready) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!enable) begin
                    state_d = StDrain;
                end else if (underrun) begin
                    state_d = StFill;
                end
            end
            StDrain: begin
                if (frame_end) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign busy        = (state_q != StIdle);
    assign hsync       = !(busy && (hcnt_q < HSyncEnd));
    assign vsync       = !(busy && (vcnt_q < VSyncEnd));
    assign rfifo_rd_en = rd_en;
    assign disp_en     = (state_q == StRun) && disp_win;
    assign frame_start = ((state_q == StFill) || (state_q == StRun)) &&
                         (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_rd_scheduler.sv
// Randomized scoreboard bench for vga_rd_scheduler using a shrunken frame geometry and a
// frame-position reference model.
module tb_vga_rd_scheduler;

    localparam int HS = 4, HB = 3, HD = 8, HT = 20;
    localparam int VS = 2, VB = 3, VD = 6, VT = 14;
    localparam int PF = 2;
    localparam int FRAME = HT * VT;

    localparam int M_IDLE = 0, M_FILL = 1, M_RUN = 2, M_DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        rfifo_rd_ready = 1'b0;
    logic        clr_err = 1'b0;
    logic [11:0] hcnt, vcnt;
    logic        hsync, vsync, rfifo_rd_en, disp_en, frame_start, underflow, busy;

    vga_rd_scheduler #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_TOTAL(VT),
        .PREFETCH(PF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .rfifo_rd_ready(rfifo_rd_ready),
        .clr_err(clr_err),
        .hcnt(hcnt),
        .vcnt(vcnt),
        .hsync(hsync),
        .vsync(vsync),
        .rfifo_rd_en(rfifo_rd_en),
        .disp_en(disp_en),
        .frame_start(frame_start),
        .underflow(underflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: mode plus linear pixel position within the frame.
    int m_mode = M_IDLE;
    int m_pos  = 0;
    bit m_uf   = 1'b0;

    logic [30:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    function automatic bit in_rd_window(int pos);
        int h = pos % HT;
        int v = pos / HT;
        return (h >= HS + HB - PF) && (h < HS + HB + HD - PF) && (v >= VS + VB) && (v < VS + VB + VD);
    endfunction

    function automatic bit in_disp_window(int pos);
        int h = pos % HT;
        int v = pos / HT;
        return (h >= HS + HB) && (h < HS + HB + HD) && (v >= VS + VB) && (v < VS + VB + VD);
    endfunction

    function automatic logic [30:0] model_out();
        int  h = m_pos % HT;
        int  v = m_pos / HT;
        bit  act = (m_mode != M_IDLE);
        logic [11:0] eh = 12'(h);
        logic [11:0] ev = 12'(v);
        logic ehs = !(act && h < HS);
        logic evs = !(act && v < VS);
        logic erd = (m_mode == M_RUN) && in_rd_window(m_pos);
        logic eds = (m_mode == M_RUN) && in_disp_window(m_pos);
        logic efs = (m_mode == M_FILL || m_mode == M_RUN) && m_pos == 0;
        return {eh, ev, ehs, evs, erd, eds, efs, m_uf, act};
    endfunction

    task automatic model_step(input bit i_rst, input bit i_en, input bit i_rdy, input bit i_clr);
        bit fault;
        int nxt;
        if (i_rst) begin
            m_mode = M_IDLE;
            m_pos  = 0;
            m_uf   = 1'b0;
            return;
        end
        fault = (m_mode == M_RUN) && in_rd_window(m_pos) && !i_rdy;
        if (fault) m_uf = 1'b1;
        else if (i_clr) m_uf = 1'b0;
        nxt = m_mode;
        case (m_mode)
            M_IDLE:  if (i_en) nxt = M_FILL;
            M_FILL:  if (!i_en) nxt = M_DRAIN;
                     else if (i_rdy && m_pos == (VS + VB) * HT - 1) nxt = M_RUN;
            M_RUN:   if (!i_en) nxt = M_DRAIN;
                     else if (fault) nxt = M_FILL;
            default: if (m_pos == FRAME - 1) nxt = M_IDLE;
        endcase
        m_pos  = (m_mode == M_IDLE) ? 0 : (m_pos + 1) % FRAME;
        m_mode = nxt;
    endtask

    // Each argument is a per-mille probability for that input's "unusual" value.
    task automatic run_cycles(input int n, input int en_off_pm, input int rdy_off_pm,
                              input int clr_pm, input int rst_pm);
        for (int i = 0; i < n; i++) begin
            rst            = ($urandom_range(999) < rst_pm);
            enable         = !($urandom_range(999) < en_off_pm);
            rfifo_rd_ready = !($urandom_range(999) < rdy_off_pm);
            clr_err        = ($urandom_range(999) < clr_pm);
            @(posedge clk);
            model_step(rst, enable, rfifo_rd_ready, clr_err);
            exp_q.push_back(model_out());
            cyc++;
            #1;
        end
    endtask

    always @(negedge clk) begin
        logic [30:0] act, e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {hcnt, vcnt, hsync, vsync, rfifo_rd_en, disp_en, frame_start, underflow, busy};
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL outputs cyc=%0d {hcnt,vcnt,hs,vs,rd,de,fs,uf,busy} got=%0d,%0d,%b got_flags=%b exp=%0d,%0d exp_flags=%b",
                         cyc, act[30:19], act[18:7], act[6:0], act[6:0], e[30:19], e[18:7], e[6:0]);
            end
        end
    end

    initial begin
        run_cycles(4, 0, 0, 0, 1000);
        run_cycles(700, 0, 0, 0, 0);          // startup into steady RUN
        run_cycles(3, 0, 0, 0, 1000);
        run_cycles(300, 0, 1000, 0, 0);       // FIFO never ready: frame stays blank
        run_cycles(600, 0, 0, 0, 0);          // ready in following frame
        run_cycles(2500, 0, 20, 15, 0);       // random underruns and clears
        run_cycles(150, 0, 0, 0, 0);
        run_cycles(700, 1000, 0, 0, 0);       // disable: drain to idle
        run_cycles(400, 0, 0, 0, 0);
        run_cycles(200, 0, 0, 0, 0);
        run_cycles(300, 500, 0, 0, 0);        // enable chatter, mostly during drain
        run_cycles(3000, 3, 10, 30, 1);       // everything mixed, occasional reset
        run_cycles(300, 0, 0, 1000, 0);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_rd_scheduler.md
VGA_RD_SCHEDULER -- requirements
Module: vga_rd_scheduler

Interface
REQ-001 SHALL have parameter H_SYNC, default 96: horizontal sync width, pixels.
REQ-002 SHALL have parameter H_BACK, default 48: horizontal back porch.
REQ-003 SHALL have parameter H_DISP, default 640: active pixels per line.
REQ-004 SHALL have parameter H_TOTAL, default 800: pixels per line.
REQ-005 SHALL have parameter V_SYNC, default 2; V_BACK, default 33; V_DISP, default 480; V_TOTAL, default 525: vertical equivalents, in lines.
REQ-006 SHALL have parameter PREFETCH, default 2: FIFO read lead, in clocks, before first active pixel.
REQ-007 SHALL have port clk, input, 1: 25 MHz pixel clock; single clock domain.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port enable, input, 1: display run request.
REQ-010 SHALL have port rfifo_rd_ready, input, 1: read FIFO holds enough pixels to stream.
REQ-011 SHALL have port clr_err, input, 1: clears the underflow flag.
REQ-012 SHALL have ports hcnt and vcnt, output, 12 each: pixel and line counters.
REQ-013 SHALL have ports hsync and vsync, output, 1 each: active-low sync.
REQ-014 SHALL have port rfifo_rd_en, output, 1: FIFO read strobe.
REQ-015 SHALL have port disp_en, output, 1: pixel-data-valid window.
REQ-016 SHALL have port frame_start, output, 1: one-cycle pulse requesting the SDRAM side to begin a new frame read.
REQ-017 SHALL have port underflow, output, 1: sticky error flag.
REQ-018 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-019 SHALL implement states IDLE, FILL, RUN, DRAIN.
REQ-020 IDLE: hcnt=vcnt=0, counters held; when enable=1, go to FILL at the next clock and start counting.
REQ-021 Counters, in non-IDLE states: hcnt increments each clock and wraps at H_TOTAL-1 to 0; vcnt increments when hcnt=H_TOTAL-1 and wraps at V_TOTAL-1 to 0.
REQ-022 hsync SHALL be 0 iff hcnt<H_SYNC and state!=IDLE; vsync SHALL be 0 iff vcnt<V_SYNC and state!=IDLE; both SHALL be 1 in IDLE.
REQ-023 frame_start SHALL pulse for 1 cycle when hcnt=0 and vcnt=0 in FILL or RUN, and on the first cycle after leaving IDLE.
REQ-024 FILL: if rfifo_rd_ready=1 when hcnt=H_TOTAL-1 and vcnt=V_SYNC+V_BACK-1, go to RUN; otherwise stay in FILL, blank the whole frame, and retry on the next frame.
REQ-025 RUN: rfifo_rd_en=1 iff hcnt is in [H_SYNC+H_BACK-PREFETCH, H_SYNC+H_BACK+H_DISP-PREFETCH) and vcnt is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
REQ-026 disp_en=1 iff state=RUN, hcnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP), and vcnt is in the active range.
REQ-027 rfifo_rd_en and disp_en SHALL be 0 in IDLE, FILL and DRAIN.
REQ-028 In RUN, rfifo_rd_en=1 with rfifo_rd_ready=0 SHALL set underflow and go to FILL next clock; the rest of that frame is blanked, and the frame restarts at the next frame_start.
REQ-029 enable=0 in FILL or RUN SHALL go to DRAIN; DRAIN keeps sync running with reads off, then goes to IDLE when hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1.
REQ-030 enable=1 in DRAIN SHALL have no effect until IDLE is reached.
REQ-031 underflow SHALL clear on clr_err=1; if a set condition and clr_err occur in the same cycle, set wins.
REQ-032 All outputs SHALL decode from registered state and counters, with 0-cycle latency and no glitch-sensitive logic.
REQ-033 Per active line in RUN there SHALL be exactly H_DISP rd_en cycles and exactly H_DISP disp_en cycles.

Reset
REQ-034 rst=1 SHALL, at the next clock edge, force IDLE, hcnt=0, vcnt=0, hsync=1, vsync=1, rfifo_rd_en=0, disp_en=0, frame_start=0, underflow=0, busy=0, regardless of current state, including mid-frame.

Verification
REQ-035 Reset, then enable=1 with rfifo_rd_ready=1 -> frame_start at cycle 1; RUN entered at end of line 34; first rd_en at hcnt=142 of vcnt=35; first disp_en at hcnt=144.
REQ-036 Steady RUN over one full frame -> 640 rd_en per line on lines 35..514 (307200 total); hsync low 96 clocks per line; vsync low for lines 0..1.
REQ-037 rfifo_rd_ready=0 through line 34 of frame 1 -> stays in FILL with no rd_en that frame; rfifo_rd_ready=1 in frame 2 -> RUN from line 35 of frame 2.
REQ-038 Drop rfifo_rd_ready at vcnt=100, hcnt=300 -> underflow=1 next clock, rd_en/disp_en=0 to end of frame, FILL; clr_err together with a fresh underflow -> underflow stays 1.
REQ-039 enable=0 at vcnt=200 -> DRAIN with no reads; IDLE entered after hcnt=799, vcnt=524; counters reset to 0.
REQ-040 rst=1 at vcnt=300 in RUN -> all outputs at their reset values next clock; busy=0.
